// File: rtl/bin2gray_serial_5bit_pkg.sv
// Shared constants and state encoding for the serial binary-to-Gray converter.
// Word width, bit-counter width and the handshake FSM states live here.
package bin2gray_serial_5bit_pkg;

   localparam int B2G_WIDTH = 5;
   localparam int CNT_W     = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SER  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bin2gray_serial_5bit_bit_fsm.sv
// One-bit Gray encoder stage: registered out = in XOR previous in.
// The previous-bit memory is cleared whenever en is low, so each word starts fresh.
module bin_gray_bit_fsm (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic in,
   output logic out
);

   logic prev_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out      <= 1'b0;
         prev_reg <= 1'b0;
      end else if (en) begin
         out      <= in ^ prev_reg;
         prev_reg <= in;
      end else begin
         // out holds between words; prev restarts at 0 for the next MSB
         prev_reg <= 1'b0;
      end
   end

endmodule

// File: rtl/bin2gray_serial_5bit.sv
// Serial binary-to-Gray converter: accepts a word, streams Gray bits MSB first,
// then presents the whole Gray word with a one-cycle out_valid pulse.
module bin2gray_serial_5bit
   import bin2gray_serial_5bit_pkg::*;
#(
   parameter int WIDTH = B2G_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] bin_in,
   output logic             ser_out,
   output logic             ser_valid,
   output logic [WIDTH-1:0] gray_out,
   output logic             out_valid
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state_reg;
   logic [WIDTH:0]   shreg_reg;   // extra top bit keeps the previously shifted-out binary bit
   logic [WIDTH-2:0] coll_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [WIDTH-1:0] gray_out_reg;
   logic             in_ready_reg;
   logic             ser_valid_reg;
   logic             out_valid_reg;

   logic bit_en;
   logic bit_in;
   logic gray_bit;

   assign bit_en   = (state_reg == SER);
   assign bit_in   = shreg_reg[WIDTH-1];
   assign gray_bit = shreg_reg[WIDTH] ^ shreg_reg[WIDTH-1];

   bin_gray_bit_fsm u_bit_fsm (
      .clk (clk),
      .rst (rst),
      .en  (bit_en),
      .in  (bit_in),
      .out (ser_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         shreg_reg     <= '0;
         coll_reg      <= '0;
         cnt_reg       <= '0;
         gray_out_reg  <= '0;
         in_ready_reg  <= 1'b1;
         ser_valid_reg <= 1'b0;
         out_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               ser_valid_reg <= 1'b0;
               out_valid_reg <= 1'b0;
               in_ready_reg  <= 1'b1;
               if (in_valid && in_ready_reg) begin
                  shreg_reg    <= {1'b0, bin_in};
                  coll_reg     <= '0;
                  cnt_reg      <= '0;
                  in_ready_reg <= 1'b0;
                  state_reg    <= SER;
               end
            end
            SER: begin
               ser_valid_reg <= 1'b1;
               shreg_reg     <= {shreg_reg[WIDTH-1:0], 1'b0};
               coll_reg      <= {coll_reg[WIDTH-3:0], gray_bit};
               if (cnt_reg == LAST_CNT) begin
                  gray_out_reg  <= {coll_reg, gray_bit};
                  out_valid_reg <= 1'b1;
                  state_reg     <= DONE;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            DONE: begin
               ser_valid_reg <= 1'b0;
               out_valid_reg <= 1'b0;
               in_ready_reg  <= 1'b1;
               state_reg     <= IDLE;
            end
            default: begin
               state_reg     <= IDLE;
               shreg_reg     <= '0;
               coll_reg      <= '0;
               cnt_reg       <= '0;
               gray_out_reg  <= '0;
               in_ready_reg  <= 1'b1;
               ser_valid_reg <= 1'b0;
               out_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign ser_valid = ser_valid_reg;
   assign gray_out  = gray_out_reg;
   assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_bin2gray_serial_5bit.sv
// Randomized and directed bench for bin2gray_serial_5bit against a Gray-code model
// (g = b ^ (b >> 1), bits emitted MSB first).
module tb_bin2gray_serial_5bit;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] bin_in;
   logic       ser_out;
   logic       ser_valid;
   logic [4:0] gray_out;
   logic       out_valid;

   int errors = 0;
   int checks = 0;
   logic [4:0] last_gray = 5'd0;

   always #5 clk = ~clk;

   bin2gray_serial_5bit #(.WIDTH(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bin_in    (bin_in),
      .ser_out   (ser_out),
      .ser_valid (ser_valid),
      .gray_out  (gray_out),
      .out_valid (out_valid)
   );

   function automatic logic [4:0] gray_of(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Push one word through; optionally keep in_valid high with junk bin_in during SER.
   task automatic run_word(input logic [4:0] b, input bit scramble);
      logic [4:0] g;
      int waitc;
      g = gray_of(b);
      waitc = 0;
      while (in_ready !== 1'b1 && waitc < 20) begin
         @(posedge clk); #1;
         waitc++;
      end
      if (in_ready !== 1'b1) begin
         check("ready_timeout", 32'(in_ready), 32'd1);
         return;
      end
      in_valid = 1'b1;
      bin_in   = b;
      @(posedge clk); #1;
      check("accept_ready_low", 32'(in_ready), 32'd0);
      check("e0_ser_valid", 32'(ser_valid), 32'd0);
      if (!scramble) in_valid = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         if (scramble) bin_in = 5'($urandom);
         @(posedge clk); #1;
         check("ser_valid", 32'(ser_valid), 32'd1);
         check("ser_bit", 32'(ser_out), 32'(g[5-k]));
         check("out_valid_timing", 32'(out_valid), 32'(k == 5));
         if (k == 5) check("gray_word", 32'(gray_out), 32'(g));
         else        check("gray_hold", 32'(gray_out), 32'(last_gray));
      end
      @(posedge clk); #1;
      check("e6_out_valid", 32'(out_valid), 32'd0);
      check("e6_ser_valid", 32'(ser_valid), 32'd0);
      check("e6_in_ready", 32'(in_ready), 32'd1);
      check("ser_out_hold", 32'(ser_out), 32'(g[0]));
      check("gray_after", 32'(gray_out), 32'(g));
      last_gray = g;
      in_valid  = 1'b0;
      $display("word bin=%b gray_exp=%b gray_out=%b", b, g, gray_out);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         acc_cycles[$];
      logic [4:0] acc_words[$];
      int         pending_cycles[$];
      logic [4:0] pending_words[$];
      int         pulses;
      int         head_c;
      logic [4:0] head_w;
      logic [4:0] w;
      logic       rdy;

      rst      = 1'b1;
      in_valid = 1'b0;
      bin_in   = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_ser_out", 32'(ser_out), 32'd0);
      check("rst_ser_valid", 32'(ser_valid), 32'd0);
      check("rst_gray_out", 32'(gray_out), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      rst = 1'b0;

      run_word(5'b00000, 1'b0);
      run_word(5'b10110, 1'b0);
      run_word(5'b11111, 1'b1);
      run_word(5'b01101, 1'b0);

      // in_valid held high, bin_in changing every cycle
      pulses = 0;
      in_valid = 1'b1;
      for (int c = 0; c < 35; c++) begin
         w      = 5'($urandom);
         bin_in = w;
         rdy    = in_ready;
         @(posedge clk); #1;
         if (rdy) begin
            acc_cycles.push_back(c);
            acc_words.push_back(w);
            pending_cycles.push_back(c);
            pending_words.push_back(w);
         end
         if (out_valid) begin
            pulses++;
            if (pending_cycles.size() == 0) begin
               check("burst_unexpected_pulse", 32'd1, 32'd0);
            end else begin
               head_c = pending_cycles.pop_front();
               head_w = pending_words.pop_front();
               check("burst_latency", 32'(c - head_c), 32'd5);
               check("burst_gray", 32'(gray_out), 32'(gray_of(head_w)));
               last_gray = gray_of(head_w);
               $display("burst bin=%b gray_out=%b cycle=%0d", head_w, gray_out, c);
            end
         end
      end
      in_valid = 1'b0;
      check("burst_accepts", 32'(acc_cycles.size()), 32'd5);
      check("burst_pulses", 32'(pulses), 32'd5);
      if (acc_cycles.size() > 0) check("burst_first_accept", 32'(acc_cycles[0]), 32'd0);
      for (int i = 1; i < acc_cycles.size(); i++)
         check("burst_interval", 32'(acc_cycles[i] - acc_cycles[i-1]), 32'd7);
      @(posedge clk); #1;

      // reset in the middle of a word, after E3
      in_valid = 1'b1;
      bin_in   = 5'b10110;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_ser_valid", 32'(ser_valid), 32'd0);
      check("midrst_gray_out", 32'(gray_out), 32'd0);
      check("midrst_ser_out", 32'(ser_out), 32'd0);
      last_gray = 5'd0;
      @(posedge clk); #1;
      rst = 1'b0;
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (out_valid) pulses++;
      end
      check("midrst_no_pulse", 32'(pulses), 32'd0);
      $display("midword reset gray_out=%b", gray_out);
      run_word(5'b01101, 1'b0);

      // exhaustive sweep
      for (int b = 0; b < 32; b++) run_word(5'(b), 1'b0);

      // random words, random junk during SER
      for (int i = 0; i < 30; i++) run_word(5'($urandom_range(0, 31)), 1'($urandom));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bin2gray_serial_5bit.md
BIN2GRAY_SERIAL_5BIT -- requirements
Module: bin2gray_serial_5bit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, giving the word width in bits; only 5 is required to be supported.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: bin_in holds a word to convert.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a word this cycle.
REQ-006 The block SHALL have port bin_in, input, WIDTH bits: the binary word to convert.
REQ-007 The block SHALL have port ser_out, output, 1 bit: the Gray bit stream, MSB first.
REQ-008 The block SHALL have port ser_valid, output, 1 bit: ser_out carries a valid Gray bit.
REQ-009 The block SHALL have port gray_out, output, WIDTH bits: the last completed Gray word.
REQ-010 The block SHALL have port out_valid, output, 1 bit: a one-cycle pulse marking a new gray_out.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SER and DONE.
REQ-012 In IDLE, in_ready SHALL be 1; in SER and DONE, in_ready SHALL be 0.
REQ-013 An accept SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-014 At the accept edge (E0), the block SHALL load bin_in into the input shift register, clear the bit counter and the previous-bit register, and enter SER.
REQ-015 bin_in SHALL be sampled only at the accept edge; in_valid and bin_in in SER or DONE SHALL be ignored.
REQ-016 On each SER edge Ek (k=1..5), the block SHALL take b = shift-register MSB and set ser_out <= b XOR prev, prev <= b, shift the input register left by one, and shift the Gray bit into the output collector LSB.
REQ-017 The result SHALL be g[4]=b[4] and g[i]=b[i] XOR b[i+1] for i=3..0, emitted g[4] first.
REQ-018 ser_valid SHALL be 1 for exactly the 5 cycles following E1..E5, and 0 otherwise.
REQ-019 At E5, the block SHALL load the collected word into gray_out, set out_valid to 1, and enter DONE.
REQ-020 At E6, the block SHALL clear out_valid and return to IDLE; in_ready SHALL be 1 after E6.
REQ-021 Latency from accept to out_valid SHALL be 5 cycles; with in_valid held high, accepts SHALL occur every 7 cycles.
REQ-022 gray_out SHALL hold its value until the next E5, and SHALL be unaffected by in_valid at any other time.
REQ-023 ser_out SHALL hold its last value when ser_valid=0.
REQ-024 The bit counter SHALL count 0..4 in SER and never wrap in any other state.
REQ-025 An unreachable state encoding SHALL return the FSM to IDLE on the next edge, with all outputs driven to their reset values.

Reset
REQ-026 While rst=1, regardless of clk, the block SHALL hold state=IDLE, in_ready=1, ser_out=0, ser_valid=0, gray_out=0, out_valid=0, counter=0 and prev=0, and clear both shift registers.
REQ-027 A reset asserted mid-word SHALL discard the partial word without asserting out_valid.
REQ-028 After reset release, the first rising edge with in_valid=1 SHALL be an accept.

Structure
REQ-029 A shared package SHALL hold the WIDTH constant, the state encoding (IDLE, SER, DONE) and the counter width.
REQ-030 The per-bit XOR/prev-bit logic SHALL be one sub-module, bin_gray_bit_fsm, with ports clk, rst, en, in and out, and a one-cycle registered output.
REQ-031 The top level SHALL contain the handshake FSM, the input PISO register and the output SIPO collector.

Verification
REQ-032 The bench SHALL cover: reset, then bin_in=5'b00000 accepted -> ser_out 0,0,0,0,0; gray_out=5'b00000 with out_valid 5 cycles after accept.
REQ-033 The bench SHALL cover: bin_in=5'b10110 -> ser_out 1,1,1,0,1; gray_out=5'b11101.
REQ-034 The bench SHALL cover: bin_in=5'b11111 -> gray_out=5'b10000; bin_in=5'b01101 -> gray_out=5'b01011.
REQ-035 The bench SHALL cover: in_valid held high with changing bin_in -> accepts exactly every 7 cycles; bin_in changes during SER have no effect on the result.
REQ-036 The bench SHALL cover: rst pulsed after E3 -> no out_valid, gray_out=0, in_ready=1 immediately; the next word converts correctly.
REQ-037 The bench SHALL cover: all 32 inputs sequentially -> each gray_out equals b XOR (b>>1), with exactly one out_valid pulse per accept.
